uart_cmd_responder: RTL

- Vehicle-side end of the host command link; the host-side remote sends 3-byte command frames and waits for a 1-byte response.
- Deserializes UART RX into {cmd[7:0], data[15:0]} and presents them with a ready flag to the flight command FSM.
- Serializes a single response byte (e.g. 0xA5 positive ack) back on TX on request.
- Sits between the board RX/TX pins and the command-processing logic inside the QuadCopter top level.

---
 rtl/quad_cmd_pkg.sv | 18 +
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/uart_cmd_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/quad_cmd_pkg.sv
// Shared opcodes, response codes and state types for the host command link.
package quad_cmd_pkg;

   localparam int BAUD_DIV_DEFAULT = 2604;

   localparam logic [7:0] SET_PITCH    = 8'h02;
   localparam logic [7:0] SET_ROLL     = 8'h03;
   localparam logic [7:0] SET_YAW      = 8'h04;
   localparam logic [7:0] SET_THRST    = 8'h05;
   localparam logic [7:0] CALIBRATE    = 8'h06;
   localparam logic [7:0] E_LAND       = 8'h07;
   localparam logic [7:0] MOTORS_OFF   = 8'h08;
   localparam logic [7:0] RESP_POS_ACK = 8'hA5;

   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} asm_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop sync, start-bit edge detect, centre sampling,
// byte_rdy on a good stop bit, frm_err on a low stop bit.
module uart_rx_byte
   import quad_cmd_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   output logic [7:0] rx_byte,
   output logic       byte_rdy,
   output logic       frm_err,
   output logic       busy
);

   localparam int CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   rx_state_t       state;
   logic            rx_s1, rx_s2, rx_s3;
   logic [CW-1:0]   cnt;
   logic [3:0]      bit_cnt;
   logic [7:0]      shift;

   assign busy = (state != RX_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         state    <= RX_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         rx_byte  <= '0;
         byte_rdy <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         rx_s1    <= RX;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         byte_rdy <= 1'b0;
         frm_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (rx_s3 && !rx_s2) state <= RX_START;
            end
            RX_START: begin
               // A start bit that is high again at half-bit is a glitch
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_s2, shift[7:1]};
                  if (bit_cnt == 4'd7) state <= RX_STOP;
                  else                 bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= RX_IDLE;
                  if (rx_s2) begin
                     rx_byte  <= shift;
                     byte_rdy <= 1'b1;
                  end else begin
                     frm_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_cmd_responder.sv
// Host command link: 3-byte frame assembler over UART RX plus 1-byte response TX.
// Optional inter-byte timeout enabled by defining UART_CMD_RX_TIMEOUT_EN.
module uart_cmd_responder
   import quad_cmd_pkg::*;
#(
   parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
   parameter int TIMEOUT_CYC = 130000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        overrun,
   output logic        frm_err,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        tx_busy,
   output logic        resp_sent
);

   localparam int CW = $clog2(BAUD_DIV) + 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BIT_PRE  = CW'(BAUD_DIV - 2);

   logic [7:0] rx_byte;
   logic       byte_rdy, rx_busy;

   uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .RX       (RX),
      .rx_byte  (rx_byte),
      .byte_rdy (byte_rdy),
      .frm_err  (frm_err),
      .busy     (rx_busy)
   );

   asm_state_t state;
   logic [7:0] cmd_tmp, hi_tmp;

`ifdef UART_CMD_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (rst || state == IDLE || rx_busy) to_cnt <= '0;
      else if (to_cnt != TO_LAST)          to_cnt <= to_cnt + 1'b1;
   end
`else
   logic unused_to;
   assign unused_to = rx_busy ^ (TIMEOUT_CYC == 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cmd_tmp <= '0;
         hi_tmp  <= '0;
         cmd     <= '0;
         data    <= '0;
         cmd_rdy <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         // Clear first so a completing frame in the same cycle wins
         if (clr_cmd_rdy) cmd_rdy <= 1'b0;
         if (frm_err) begin
            state <= IDLE;
         end else if (byte_rdy) begin
            case (state)
               IDLE: begin
                  cmd_tmp <= rx_byte;
                  state   <= WAIT_HI;
               end
               WAIT_HI: begin
                  hi_tmp <= rx_byte;
                  state  <= WAIT_LO;
               end
               WAIT_LO: begin
                  cmd     <= cmd_tmp;
                  data    <= {hi_tmp, rx_byte};
                  cmd_rdy <= 1'b1;
                  overrun <= cmd_rdy;
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
`ifdef UART_CMD_RX_TIMEOUT_EN
         else if (state != IDLE && to_cnt == TO_LAST) begin
            state <= IDLE;
         end
`endif
      end
   end

   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '1;
      end else begin
         resp_sent <= 1'b0;
         if (!tx_busy) begin
            TX <= 1'b1;
            if (send_resp) begin
               tx_busy  <= 1'b1;
               TX       <= 1'b0;
               tx_shift <= {1'b1, resp};
               tx_cnt   <= '0;
               tx_bit   <= '0;
            end
         end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
               TX      <= 1'b1;
            end else begin
               tx_bit   <= tx_bit + 1'b1;
               TX       <= tx_shift[0];
               tx_shift <= {1'b1, tx_shift[8:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
            // Registered, so it is visible during the final stop-bit cycle
            if (tx_bit == 4'd9 && tx_cnt == BIT_PRE) resp_sent <= 1'b1;
         end
      end
   end

endmodule
